// File: rtl/instmem_loader.sv
// instmem_loader: streams a length-prefixed byte image into instruction memory while holding the core.
// Define INSTMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module instmem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif
    localparam bit FIN_DONE = (FIN == DONE);
    state_t      state_q;
    logic [15:0] len_q, word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] shift_q;
    logic [7:0]  csum_q;
    logic        mem_we_q, core_hold_q, done_q, err_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        data_open, accept;
    logic [15:0] len_full;
    // The last word's write cycle stays in DATA with in_ready low, so core_hold covers it before DONE.
    assign data_open = (state_q == DATA) && (word_idx_q != len_q);
    assign in_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == CSUM) || data_open;
    assign accept    = in_valid && in_ready;
    assign len_full  = {len_q[15:8], in_data};
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            core_hold_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: if (start) begin
                    state_q     <= LEN_HI;
                    word_idx_q  <= '0;
                    byte_idx_q  <= '0;
                    csum_q      <= '0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    core_hold_q <= 1'b1;
                end
                LEN_HI: if (accept) begin
                    len_q[15:8] <= in_data;
                    state_q     <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    len_q <= len_full;
                    if ({16'b0, len_full} > 32'(MAX_WORDS)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_q     <= FIN;
                        done_q      <= FIN_DONE;
                        core_hold_q <= !FIN_DONE;
                    end else
                        state_q <= DATA;
                end
                DATA: if (word_idx_q == len_q) begin
                    state_q     <= FIN;
                    done_q      <= FIN_DONE;
                    core_hold_q <= !FIN_DONE;
                end else if (accept) begin
                    shift_q    <= {shift_q[15:0], in_data};
                    byte_idx_q <= byte_idx_q + 2'd1;
                    csum_q     <= csum_q ^ in_data;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= {shift_q, in_data};
                        mem_addr_q  <= BASE_ADDR + {14'b0, word_idx_q, 2'b00};
                        word_idx_q  <= word_idx_q + 16'd1;
                    end
                end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                CSUM: if (accept) begin
                    state_q     <= (in_data == csum_q) ? DONE : ERR;
                    done_q      <= (in_data == csum_q);
                    err_q       <= (in_data != csum_q);
                    core_hold_q <= (in_data != csum_q);
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instmem_loader.sv
// tb_instmem_loader: random sessions checked against a queue-based model of the expected writes and final status.
module tb_instmem_loader;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam int          MAXW = 256;
    logic        clk = 0, rst = 1, start = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, mem_we, core_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] words[$], got_a[$], got_d[$];
    int tests = 0, fails = 0;

    instmem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (mem_we) begin
        got_a.push_back(mem_addr);
        got_d.push_back(mem_wdata);
        chk("hold_during_we", {31'b0, core_hold}, 1);
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data = b;
        in_valid = 1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", {31'b0, in_ready}, 1);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
        chk("hold_after_start", {29'b0, core_hold, done, err}, 32'b100);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, {27'b0, in_ready, mem_we, core_hold, done, err}, 0);
        chk({tag, "_addr"}, mem_addr, BASE);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    // gap: 0 back-to-back, 1 idle cycle between bytes, 2 random 0..2 idle cycles
    task automatic session(input int len, input int gap, input bit mid_start, input bit bad_cs,
                           input logic [31:0] first);
        logic [15:0] l16;
        logic [31:0] w;
        logic [7:0]  cs, bt;
        bit          exp_err;
        int          n, nexp;
        l16 = 16'(len);
        words.delete();
        got_a.delete();
        got_d.delete();
        for (int i = 0; i < len && len <= MAXW; i++) words.push_back(i == 0 ? first : $urandom);
        exp_err = len > MAXW;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        exp_err = exp_err || bad_cs;
`endif
        nexp = (len > MAXW) ? 0 : len;
        pulse_start();
        send(l16[15:8]);
        send(l16[7:0]);
        cs = 0;
        if (len <= MAXW) begin
            for (int i = 0; i < len; i++) begin
                w = words[i];
                for (int b = 0; b < 4; b++) begin
                    bt = w[8*(3-b) +: 8];
                    cs ^= bt;
                    send(bt);
                    repeat (gap == 2 ? $urandom_range(0, 2) : gap) @(negedge clk);
                end
                if (mid_start && i == 0) pulse_start();
            end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            send(bad_cs ? cs ^ 8'h01 : cs);
`endif
        end
        n = 0;
        while (!(done || err) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("end_done", {31'b0, done}, {31'b0, !exp_err});
        chk("end_err", {31'b0, err}, {31'b0, exp_err});
        chk("end_hold", {31'b0, core_hold}, {31'b0, exp_err});
        chk("end_ready", {31'b0, in_ready}, 0);
        chk("write_count", got_a.size(), nexp);
        for (int i = 0; i < nexp && i < got_a.size(); i++) begin
            chk("wr_addr", got_a[i], BASE + 32'(4 * i));
            chk("wr_data", got_d[i], words[i]);
        end
        if (nexp > 0) begin
            chk("hold_addr", mem_addr, BASE + 32'(4 * (nexp - 1)));
            chk("hold_wdata", mem_wdata, words[nexp-1]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        @(negedge clk);
        check_reset_outputs("idle");
        session(1, 0, 0, 0, 32'h2008_0005);
        session(3, 1, 0, 0, $urandom);
        session(257, 0, 0, 0, 0);
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        session(1, 0, 0, 1, 32'h1122_3344);
`endif
        // reset mid-word, with start and a valid byte in the same cycle
        got_a.delete();
        pulse_start();
        send(8'h00);
        send(8'h02);
        send(8'hAB);
        send(8'hCD);
        rst = 1;
        start = 1;
        in_valid = 1;
        in_data = 8'hEF;
        @(negedge clk);
        rst = 0;
        start = 0;
        in_valid = 0;
        check_reset_outputs("midrst");
        chk("midrst_nowrite", got_a.size(), 0);
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst_idle");
        session(2, 0, 0, 0, $urandom);
        session(4, 2, 1, 0, $urandom);
        session(0, 0, 0, 0, 0);
        session(6, 0, 0, 0, $urandom);
        for (int k = 0; k < 6; k++) session($urandom_range(1, 8), 2, $urandom_range(0, 1), 0, $urandom);
        session(256, 0, 0, 0, $urandom);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
